// File: rtl/sd_cmd_engine_pkg.sv
// Shared constants for the SD CMD-line engine: state codes, response types, CRC7 polynomial.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sd_cmd_engine_pkg;

    // Engine states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEND  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RECV  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Response type field values
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_48   = 2'b01;
    localparam logic [1:0] RESP_136  = 2'b10;
    localparam logic [1:0] RESP_48B  = 2'b11;

    // x^7 + x^3 + 1, leading term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int FRAME_W_48  = 48;
    localparam int FRAME_W_136 = 136;

    // One serial CRC7 step, message bits MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator (x^7+x^3+1, init 0), one message bit per enabled clock.
// Latency: crc reflects a bit one clock after it is presented with en=1.
// Backpressure: none; clear has priority over en.
module sd_crc7
    import sd_cmd_engine_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    // Accumulate remainder; clear restarts a new frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= 7'h00;
        end else if (clear) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7, then captures and checks the response.
// Latency: first bit on the first sd_clk_en tick after start; done one clock after last bit (two with response check).
// Backpressure: start is ignored while busy; no other flow control.
module sd_cmd_engine
    import sd_cmd_engine_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64,
    parameter int CNT_W         = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sd_clk_en,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         crc_check_en,
    input  logic         index_check_en,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         busy,
    output logic         done,
    output logic [127:0] response,
    output logic         err_timeout,
    output logic         err_crc,
    output logic         err_index,
    output logic         err_end
);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [39:0]      tx_shift;
    logic [5:0]       idx_q;
    logic [1:0]       rtype_q;
    logic             crc_en_q;
    logic             idx_en_q;
    // Only the low 128 bits of a response are ever inspected; older bits fall off the top
    logic [127:0]     rx_frame;

    logic [6:0]       tx_crc;
    logic [6:0]       rx_crc;
    logic [7:0]       tx_crc_ext;
    logic [2:0]       crc_sel;
    logic [CNT_W-1:0] rx_top;
    logic             is_48;
    logic             is_136;
    logic             has_resp;
    logic             start_ok;
    logic             tx_crc_en;
    logic             rx_crc_en;
    logic             rx_crc_clr;
    logic             tx_bit;

    assign is_136     = (rtype_q == RESP_136);
    assign is_48      = (rtype_q == RESP_48) || (rtype_q == RESP_48B);
    assign has_resp   = is_48 || is_136;
    assign start_ok   = start && !busy && (state == ST_IDLE);

    // TX CRC covers frame bits 47..8 (the 40 header/argument bits)
    assign tx_crc_en  = (state == ST_SEND) && sd_clk_en && (cnt >= CNT_W'(8));

    // RX CRC covers frame bits [top:8]; the start bit is zero and cannot change a zero-seeded CRC
    assign rx_top     = is_136 ? CNT_W'(FRAME_W_136 - 9) : CNT_W'(FRAME_W_48 - 2);
    assign rx_crc_clr = (state == ST_WAIT) && sd_clk_en && !cmd_in;
    assign rx_crc_en  = (state == ST_RECV) && sd_clk_en &&
                        (cnt >= CNT_W'(8)) && (cnt <= rx_top);

    // Frame positions 7..1 carry crc[6..0]
    assign crc_sel    = cnt[2:0] - 3'd1;
    assign tx_crc_ext = {1'b1, tx_crc};

    // Select the outgoing frame bit for the current counter position
    always_comb begin
        tx_bit = 1'b1;
        if (cnt >= CNT_W'(8)) begin
            tx_bit = tx_shift[39];
        end else if (cnt != '0) begin
            tx_bit = tx_crc_ext[crc_sel];
        end
    end

    sd_crc7 u_tx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_ok),
        .en     (tx_crc_en),
        .bit_in (tx_shift[39]),
        .crc    (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (rx_crc_clr),
        .en     (rx_crc_en),
        .bit_in (cmd_in),
        .crc    (rx_crc)
    );

    // Command/response sequencer with registered pad and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tx_shift    <= '0;
            idx_q       <= '0;
            rtype_q     <= RESP_NONE;
            crc_en_q    <= 1'b0;
            idx_en_q    <= 1'b0;
            rx_frame    <= '0;
            cmd_out     <= 1'b1;
            cmd_oe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            response    <= '0;
            err_timeout <= 1'b0;
            err_crc     <= 1'b0;
            err_index   <= 1'b0;
            err_end     <= 1'b0;
        end else begin
            done <= 1'b0;
            // Outside SEND the pad is released on every bit time
            if (state != ST_SEND && sd_clk_en) begin
                cmd_oe  <= 1'b0;
                cmd_out <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        idx_q       <= cmd_index;
                        rtype_q     <= resp_type;
                        crc_en_q    <= crc_check_en;
                        idx_en_q    <= index_check_en;
                        tx_shift    <= {2'b01, cmd_index, cmd_arg};
                        cnt         <= CNT_W'(FRAME_W_48 - 1);
                        err_timeout <= 1'b0;
                        err_crc     <= 1'b0;
                        err_index   <= 1'b0;
                        err_end     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sd_clk_en) begin
                        cmd_oe  <= 1'b1;
                        cmd_out <= tx_bit;
                        if (cnt >= CNT_W'(8)) begin
                            tx_shift <= {tx_shift[38:0], 1'b0};
                        end
                        if (cnt == '0) begin
                            if (has_resp) begin
                                state <= ST_WAIT;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (sd_clk_en) begin
                        if (!cmd_in) begin
                            cnt      <= is_136 ? CNT_W'(FRAME_W_136 - 2) : CNT_W'(FRAME_W_48 - 2);
                            rx_frame <= '0;
                            state    <= ST_RECV;
                        end else if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            err_timeout <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RECV: begin
                    if (sd_clk_en) begin
                        rx_frame <= {rx_frame[126:0], cmd_in};
                        if (cnt == '0) begin
                            state <= ST_CHECK;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (is_136) begin
                        response  <= {8'h00, rx_frame[127:8]};
                        err_index <= 1'b0;
                    end else begin
                        response  <= {96'h0, rx_frame[39:8]};
                        err_index <= idx_en_q && (rx_frame[45:40] != idx_q);
                    end
                    err_crc <= crc_en_q && (rx_crc != rx_frame[7:1]);
                    err_end <= !rx_frame[0];
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: directed scenarios plus randomized commands against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_cmd_engine;

    localparam int TIMEOUT_TICKS = 64;
    localparam int BUDGET        = 3000;

    logic         clock;
    logic         reset;
    logic         sd_clk_en;
    logic         start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         crc_check_en;
    logic         index_check_en;
    logic         cmd_in;
    logic         cmd_out;
    logic         cmd_oe;
    logic         busy;
    logic         done;
    logic [127:0] response;
    logic         err_timeout;
    logic         err_crc;
    logic         err_index;
    logic         err_end;

    int           tests = 0;
    int           fails = 0;
    logic [127:0] exp_resp;
    logic [47:0]  last_tx;

    sd_cmd_engine #(.TIMEOUT_TICKS(TIMEOUT_TICKS), .CNT_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .sd_clk_en      (sd_clk_en),
        .start          (start),
        .cmd_index      (cmd_index),
        .cmd_arg        (cmd_arg),
        .resp_type      (resp_type),
        .crc_check_en   (crc_check_en),
        .index_check_en (index_check_en),
        .cmd_in         (cmd_in),
        .cmd_out        (cmd_out),
        .cmd_oe         (cmd_oe),
        .busy           (busy),
        .done           (done),
        .response       (response),
        .err_timeout    (err_timeout),
        .err_crc        (err_crc),
        .err_index      (err_index),
        .err_end        (err_end)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
    function automatic logic [6:0] crc7_div(input logic [135:0] m, input int n);
        logic [142:0] r;
        r = 143'(m) << 7;
        for (int i = n + 6; i >= 7; i--) begin
            if (r[i]) r = r ^ (143'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_tx(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        d = {2'b01, idx, arg};
        return {d, crc7_div(136'(d), 40), 1'b1};
    endfunction

    function automatic logic [135:0] mk_r48(input logic [5:0] idx, input logic [31:0] pl, input logic endb);
        logic [39:0] d;
        d = {2'b00, idx, pl};
        return 136'({d, crc7_div(136'(d), 40), endb});
    endfunction

    function automatic logic [135:0] mk_r136(input logic [119:0] cid, input logic endb);
        return {2'b00, 6'h3F, cid, crc7_div(136'(cid), 120), endb};
    endfunction

    // Issue one command, play the card side, and compare everything with the frame-level model
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input logic ce, input logic ie,
                           input bit respond, input logic [135:0] rf, input int gap);
        int           rlen, tick_no, oe_ticks, exp_last, extra, last_cyc, done_cyc, t, k;
        bit           got_done, busy_ok, tmo;
        logic [47:0]  tx_cap, exp_tx;
        logic         e_tmo, e_crc, e_idx, e_end;
        logic [127:0] new_resp;

        rlen   = (rt == 2'b10) ? 136 : ((rt == 2'b00) ? 0 : 48);
        tmo    = (rlen != 0) && (!respond || gap >= TIMEOUT_TICKS);
        exp_tx = mk_tx(idx, arg);
        e_tmo = 1'b0; e_crc = 1'b0; e_idx = 1'b0; e_end = 1'b0;
        new_resp = exp_resp;
        extra = 0;
        if (rlen == 0) begin
            exp_last = 48;
        end else if (tmo) begin
            exp_last = 48 + TIMEOUT_TICKS;
            e_tmo = 1'b1;
        end else begin
            exp_last = 48 + gap + rlen;
            extra = 1;
            e_end = !rf[0];
            if (rlen == 48) begin
                e_crc = ce && (crc7_div(136'(rf[47:8]), 40) != rf[7:1]);
                e_idx = ie && (rf[45:40] != idx);
                new_resp = {96'h0, rf[39:8]};
            end else begin
                e_crc = ce && (crc7_div(136'(rf[127:8]), 120) != rf[7:1]);
                new_resp = {8'h00, rf[127:8]};
            end
        end

        @(negedge clock);
        start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_type = rt;
        crc_check_en = ce; index_check_en = ie;
        sd_clk_en = 1'($urandom_range(0, 1)); cmd_in = 1'b1;
        @(posedge clock); #1;
        check({tag, "/busy_on"}, 136'(busy), 136'(1));

        tick_no = 0; oe_ticks = 0; tx_cap = '0; got_done = 0; busy_ok = 1;
        last_cyc = -1; done_cyc = -2;
        for (int cyc = 0; cyc < BUDGET && !got_done; cyc++) begin
            @(negedge clock);
            start = ($urandom_range(0, 7) == 0);
            cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
            crc_check_en = 1'($urandom); index_check_en = 1'($urandom);
            sd_clk_en = 1'($urandom_range(0, 1));
            if (sd_clk_en) begin
                tick_no++;
                t = tick_no - 48;
                cmd_in = 1'b1;
                if (respond && rlen != 0 && t > gap) begin
                    k = t - gap - 1;
                    if (k < rlen) cmd_in = rf[rlen - 1 - k];
                end
            end else begin
                cmd_in = 1'($urandom);
            end
            @(posedge clock); #1;
            if (sd_clk_en) begin
                if (tick_no <= 48) tx_cap = {tx_cap[46:0], cmd_out};
                if (cmd_oe) oe_ticks++;
                if (tick_no == exp_last) last_cyc = cyc;
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end else if (!busy) begin
                busy_ok = 0;
            end
        end
        last_tx = tx_cap;

        check({tag, "/done_seen"}, 136'(got_done), 136'(1));
        check({tag, "/tx_frame"}, 136'(tx_cap), 136'(exp_tx));
        check({tag, "/oe_ticks"}, 136'(oe_ticks), 136'(48));
        check({tag, "/done_timing"}, 136'(done_cyc), 136'(last_cyc + extra));
        check({tag, "/busy_held"}, 136'({busy_ok, busy}), 136'(2'b11));
        check({tag, "/errs"}, 136'({err_timeout, err_crc, err_index, err_end}),
              136'({e_tmo, e_crc, e_idx, e_end}));
        check({tag, "/response"}, 136'(response), 136'(new_resp));
        exp_resp = new_resp;

        // A start presented during the done cycle must be dropped
        @(negedge clock);
        start = 1'b1; sd_clk_en = 1'b1; cmd_in = 1'b1; cmd_index = 6'($urandom);
        @(posedge clock); #1;
        check({tag, "/start_at_done_ignored"}, 136'({busy, done, cmd_oe, cmd_out}), 136'(4'b0001));
        @(negedge clock);
        start = 1'b0; sd_clk_en = 1'b0;
        @(posedge clock); #1;
        check({tag, "/idle_after"}, 136'({busy, done}), 136'(2'b00));
    endtask

    localparam logic [119:0] CID = 120'h0123456789ABCDEF0123456789ABEF;

    logic [5:0]   ri;
    logic [31:0]  ra;
    logic [1:0]   rrt;
    logic         rce, rie, rend;
    bit           rresp;
    int           rgap, pos;
    logic [135:0] rf;
    bit           saw_done;

    initial begin
        reset = 1'b1; sd_clk_en = 1'b0; start = 1'b0; cmd_index = '0; cmd_arg = '0;
        resp_type = 2'b00; crc_check_en = 1'b0; index_check_en = 1'b0; cmd_in = 1'b1;
        exp_resp = '0; last_tx = '0;
        repeat (3) @(negedge clock);
        check("reset/pad", 136'({cmd_out, cmd_oe}), 136'(2'b10));
        check("reset/busy_done", 136'({busy, done}), 136'(2'b00));
        check("reset/errs", 136'({err_timeout, err_crc, err_index, err_end}), 136'(0));
        check("reset/response", 136'(response), 136'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // CMD0, no response
        run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, '0, 0);
        check("cmd0/tx_literal", 136'(last_tx), 136'(48'h40_0000_0000_95));

        // Silent card: timeout with response still at reset value
        run_cmd("tmo_a", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b0, '0, 0);
        check("tmo_a/err_timeout", 136'(err_timeout), 136'(1));

        // CMD8 with clean R7-style response after 5 idle ticks
        run_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b1, mk_r48(6'd8, 32'h1AA, 1'b1), 5);
        check("cmd8/tx_literal", 136'(last_tx), 136'(48'h48_0000_01AA_87));
        check("cmd8/response_literal", 136'(response), 136'(128'h1AA));

        // Timeout leaves the previous response in place
        run_cmd("tmo_b", 6'd8, 32'h1AA, 2'b11, 1'b1, 1'b1, 1'b0, '0, 0);
        check("tmo_b/response_kept", 136'(response), 136'(128'h1AA));

        // Corrupted argument bit
        run_cmd("crc_flip", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b1,
                mk_r48(6'd8, 32'h1AA, 1'b1) ^ (136'h1 << 20), 3);
        check("crc_flip/err_crc_idx", 136'({err_crc, err_index}), 136'(2'b10));

        // Wrong index, checked and unchecked
        run_cmd("idx_on", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b1, mk_r48(6'h09, 32'h1AA, 1'b1), 2);
        check("idx_on/err_index", 136'({err_crc, err_index}), 136'(2'b01));
        run_cmd("idx_off", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 1'b1, mk_r48(6'h09, 32'h1AA, 1'b1), 2);
        check("idx_off/err_index", 136'(err_index), 136'(0));

        // CMD2 with 136-bit CID response, then bad end bit
        run_cmd("cmd2", 6'd2, 32'h0, 2'b10, 1'b1, 1'b1, 1'b1, mk_r136(CID, 1'b1), 4);
        check("cmd2/response_literal", 136'(response), 136'({8'h00, CID}));
        run_cmd("cmd2_end", 6'd2, 32'h0, 2'b10, 1'b1, 1'b1, 1'b1, mk_r136(CID, 1'b0), 1);
        check("cmd2_end/err_end", 136'(err_end), 136'(1));

        // Start bit on the very last allowed tick, then one tick too late
        run_cmd("ncr_63", 6'd13, 32'h5555_0000, 2'b01, 1'b1, 1'b1, 1'b1,
                mk_r48(6'd13, 32'hCAFE_F00D, 1'b1), TIMEOUT_TICKS - 1);
        run_cmd("ncr_64", 6'd13, 32'h5555_0000, 2'b01, 1'b1, 1'b1, 1'b1,
                mk_r48(6'd13, 32'hCAFE_F00D, 1'b1), TIMEOUT_TICKS);

        // Randomized commands against the model
        for (int n = 0; n < 10; n++) begin
            rrt = 2'($urandom); ri = 6'($urandom); ra = $urandom;
            rce = 1'($urandom); rie = 1'($urandom);
            rresp = ($urandom_range(0, 5) != 0);
            rgap = $urandom_range(0, 12);
            rend = ($urandom_range(0, 4) != 0);
            if (rrt == 2'b10) begin
                rf = mk_r136({$urandom, $urandom, $urandom, 24'($urandom)}, rend);
                pos = $urandom_range(0, 134);
            end else begin
                rf = mk_r48(($urandom_range(0, 2) == 0) ? 6'($urandom) : ri, $urandom, rend);
                pos = $urandom_range(0, 46);
            end
            if ($urandom_range(0, 2) == 0) rf[pos] = ~rf[pos];
            run_cmd("rand", ri, ra, rrt, rce, rie, rresp, rf, rgap);
        end

        // Reset while bit 20 of the command is on the line
        @(negedge clock);
        start = 1'b1; cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; resp_type = 2'b01;
        crc_check_en = 1'b1; index_check_en = 1'b1; sd_clk_en = 1'b0; cmd_in = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 28; i++) begin
            @(negedge clock);
            start = 1'b0; sd_clk_en = 1'b1;
            @(posedge clock);
        end
        #1;
        check("rst_mid/pre_oe", 136'({cmd_oe, busy}), 136'(2'b11));
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid/pad", 136'({cmd_oe, cmd_out}), 136'(2'b01));
        check("rst_mid/busy_done", 136'({busy, done}), 136'(2'b00));
        check("rst_mid/response", 136'(response), 136'(0));
        exp_resp = '0;
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 3) reset = 1'b0;
            sd_clk_en = 1'b1;
            @(posedge clock); #1;
            if (done || busy) saw_done = 1;
        end
        check("rst_mid/no_done_after", 136'(saw_done), 136'(0));
        @(negedge clock);
        sd_clk_en = 1'b0;
        run_cmd("post_rst", 6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, '0, 0);
        check("post_rst/tx_literal", 136'(last_tx), 136'(48'h40_0000_0000_95));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Command-line engine sitting directly downstream of the host controller register file.
- Takes the latched Command register fields and the Argument register value, then serialises the 48-bit SD command frame with CRC7 onto the CMD line.
- Receives the card response (48-bit or 136-bit), checks it, and presents the 128-bit payload and error flags for loading into Response registers r6..r9 and the interrupt status registers.

Parameters:
- TIMEOUT_TICKS, 64: max SD-clock ticks to wait for a response start bit after the command end bit (Ncr).
- CNT_W, 8: width of the bit/timeout counter; must hold max(135, TIMEOUT_TICKS).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sd_clk_en  in  1  one-cycle strobe marking an SD bit time; CMD is driven/sampled only on cycles with sd_clk_en=1.
- start  in  1  pulse; request to issue a command; honoured only when busy=0.
- cmd_index  in  6  command index, latched on accepted start.
- cmd_arg  in  32  command argument, latched on accepted start.
- resp_type  in  2  00 none, 01 48-bit, 10 136-bit, 11 48-bit (busy variant; busy handled elsewhere); latched.
- crc_check_en  in  1  enable response CRC check; latched.
- index_check_en  in  1  enable response index check; latched.
- cmd_in  in  1  CMD line input from pad.
- cmd_out  out  1  CMD line output value.
- cmd_oe  out  1  CMD pad output enable.
- busy  out  1  high from accepted start until the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- response  out  128  captured response payload.
- err_timeout / err_crc / err_index / err_end  out  1 each  error flags; valid with done, held until the next accepted start.

Behaviour:
- Reset (async, any state): state IDLE; cmd_out=1; cmd_oe=0; busy=0; done=0; response=0; all err_* =0; counters=0. A reset mid-frame aborts immediately, with no done pulse.
- All outputs are registered.
- Frame layout: {1'b0, 1'b1, cmd_index, cmd_arg, crc7, 1'b1}, MSB first. crc7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
- States: IDLE, SEND, WAIT_START, RECV, CHECK, DONE.
- IDLE:
  - start=1: latch inputs; clear err_*; busy=1; go to SEND with bit counter=47.
  - start while busy=1: ignored.
  - start coincident with sd_clk_en: the first bit is still driven on the next tick, not the same cycle.
- SEND:
  - On each tick: cmd_oe=1, cmd_out=frame bit[counter], counter decrements.
  - CRC bits are taken from the serial CRC unit after 40 data bits.
  - On the tick that drives bit 0 (end bit): next state is DONE if resp_type=00, else WAIT_START with timeout counter=0.
  - cmd_oe drops on the first tick after the end bit.
- WAIT_START:
  - cmd_oe=0, cmd_out=1.
  - Each tick samples cmd_in. A 0 is the start bit: go to RECV with counter=46 (48-bit) or 134 (136-bit) and response shift register cleared.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_TICKS: err_timeout=1, go to DONE.
- RECV:
  - Each tick shifts cmd_in into a 136-bit frame register. CRC accumulates over the CRC-covered bits.
  - After the counter=0 sample, go to CHECK.
- CHECK (one clock):
  - 48-bit response: response={96'h0, frame[39:8]}. err_crc = crc_check_en & (crc7(frame[47:8]) != frame[7:1]). err_index = index_check_en & (frame[45:40] != latched index).
  - 136-bit response: response={8'h0, frame[127:8]}. err_crc = crc_check_en & (crc7(frame[127:8]) != frame[7:1]). err_index is never set.
  - Both types: err_end = (frame[0] != 1).
  - Then go to DONE.
- DONE: done=1 for exactly one clock; busy deasserts on the next cycle; go to IDLE.
- Timeout leaves response unchanged from its pre-start value (0 after reset).
- Simultaneous start and done: start is ignored, since busy=1 in DONE.

Decomposition:
- Shared include sd_defines.vh:
  - state encodings;
  - RESP_NONE/RESP_48/RESP_136/RESP_48B constants;
  - CRC7 polynomial 7'h09;
  - frame widths 48/136.
- Sub-module sd_crc7: serial CRC7. Inputs clock, reset, clear, en, bit_in; output crc[6:0].
- Use two sd_crc7 instances, one for TX and one for RX, or one shared and cleared between phases.

Test Plan:
- CMD0, arg 0, resp none → cmd_out serial stream equals 48'h40_0000_0000_95 on successive ticks; cmd_oe high for exactly 48 ticks; done 1 clock after the end-bit tick; all err_* =0.
- CMD8, arg 32'h1AA, resp 48 → TX frame 48'h48_0000_01AA_87; card model returns 08_000001AA plus bench-computed CRC7 with end bit 1 after 5 idle ticks → response=128'h1AA; no errors.
- Resp 48, cmd_in held high → err_timeout=1 and done exactly TIMEOUT_TICKS ticks after the end bit; response unchanged.
- Response with one flipped argument bit, then a separate response with index 6'h09 for CMD8 → err_crc=1 (err_index=0) in the first case; err_index=1 in the second; err_index=0 with index_check_en=0.
- CMD2, resp 136, CID 120'h0123..EF plus valid CRC → response={8'h0, CID}; no errors. The same run with end bit 0 → err_end=1.
- Reset asserted at bit 20 of SEND → same-cycle cmd_oe=0, cmd_out=1, busy=0; no done. A new start after release transmits a clean full frame.
